regfile_alu_sequencer: RTL and testbench

//  Multi-cycle command sequencer that owns the 8x8 register file's read and write ports.

---
 rtl/regfile_alu_sequencer.sv | 142 ++++++++++++++
 tb/tb_regfile_alu_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_alu_sequencer.sv
// ============================================================================
//  Module      : regfile_alu_sequencer
//  Description : Four-state command sequencer (IDLE/READ/EXEC/WRITE) that owns
//                the read and write ports of an 8x8 register file. It accepts
//                one ALU command per valid/ready handshake, reads both source
//                registers, computes the result, and writes it back. It also
//                keeps zero/carry flags for the most recent non-NOP command.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_alu_sequencer #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          Clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs,
    input  logic [AW-1:0] cmd_rt,
    input  logic [DW-1:0] cmd_imm,
    output logic [AW-1:0] RX,
    output logic [AW-1:0] RY,
    input  logic [DW-1:0] busX,
    input  logic [DW-1:0] busY,
    output logic          WEN,
    output logic [AW-1:0] RW,
    output logic [DW-1:0] busW,
    output logic          done,
    output logic          flag_zero,
    output logic          flag_carry
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_EXEC  = 2'd2;
    localparam logic [1:0] c_WRITE = 2'd3;

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_OR   = 3'b011;
    localparam logic [2:0] c_OP_XOR  = 3'b100;
    localparam logic [2:0] c_OP_ADDI = 3'b101;
    localparam logic [2:0] c_OP_LI   = 3'b110;
    localparam logic [2:0] c_OP_NOP  = 3'b111;

    logic [1:0]    r_state;
    logic [2:0]    r_op;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_imm;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW:0]   w_result;
    logic          w_wen;

    assign cmd_ready = (r_state == c_IDLE);

    // A write is suppressed for NOP and for destination r0.
    assign w_wen = (r_op != c_OP_NOP) && (r_rd != '0);

    // ALU: the extra MSB is the carry for adds and the borrow for SUB
    // (zero-extended subtraction wraps into bit DW exactly when A < B).
    always_comb begin
        w_result = '0;
        case (r_op)
            c_OP_ADD:  w_result = {1'b0, r_a} + {1'b0, r_b};
            c_OP_SUB:  w_result = {1'b0, r_a} - {1'b0, r_b};
            c_OP_AND:  w_result = {1'b0, r_a & r_b};
            c_OP_OR:   w_result = {1'b0, r_a | r_b};
            c_OP_XOR:  w_result = {1'b0, r_a ^ r_b};
            c_OP_ADDI: w_result = {1'b0, r_a} + {1'b0, r_imm};
            c_OP_LI:   w_result = {1'b0, r_imm};
            default:   w_result = '0;
        endcase
    end

    // Sequencer FSM with all regfile-facing outputs and flags registered.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_op       <= c_OP_NOP;
            r_rd       <= '0;
            r_imm      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            RX         <= '0;
            RY         <= '0;
            RW         <= '0;
            busW       <= '0;
            WEN        <= 1'b0;
            done       <= 1'b0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_rd    <= cmd_rd;
                        r_imm   <= cmd_imm;
                        RX      <= cmd_rs;
                        RY      <= cmd_rt;
                        r_state <= c_READ;
                    end
                end
                c_READ: begin
                    r_a     <= busX;
                    r_b     <= busY;
                    r_state <= c_EXEC;
                end
                c_EXEC: begin
                    busW <= w_result[DW-1:0];
                    RW   <= r_rd;
                    if (r_op != c_OP_NOP) begin
                        flag_zero  <= (w_result[DW-1:0] == '0);
                        flag_carry <= w_result[DW];
                    end
                    WEN     <= w_wen;
                    done    <= 1'b1;
                    r_state <= c_WRITE;
                end
                c_WRITE: begin
                    WEN     <= 1'b0;
                    done    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    WEN     <= 1'b0;
                    done    <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_alu_sequencer.sv
// ============================================================================
//  Module      : tb_regfile_alu_sequencer
//  Description : Directed self-checking bench for regfile_alu_sequencer with a
//                behavioural 8x8 register file attached to its ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_alu_sequencer;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_LI   = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    logic       Clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'b000;
    logic [2:0] cmd_rd = 3'd0;
    logic [2:0] cmd_rs = 3'd0;
    logic [2:0] cmd_rt = 3'd0;
    logic [7:0] cmd_imm = 8'h00;
    logic [2:0] RX, RY, RW;
    logic [7:0] busX, busY, busW;
    logic       WEN, done, flag_zero, flag_carry;

    int checks = 0;
    int errors = 0;

    // behavioural register file
    logic [7:0] rf [8];
    logic       rf_clear = 1'b1;

    assign busX = rf[RX];
    assign busY = rf[RY];

    always @(posedge Clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (WEN) begin
            rf[RW] <= busW;
        end
    end

    always #5 Clk = ~Clk;

    regfile_alu_sequencer #(.DW(8), .AW(3)) dut (
        .Clk(Clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_imm(cmd_imm),
        .RX(RX), .RY(RY), .busX(busX), .busY(busY),
        .WEN(WEN), .RW(RW), .busW(busW), .done(done),
        .flag_zero(flag_zero), .flag_carry(flag_carry)
    );

    // observations captured by run_cmd, one set per phase
    logic       o_ready_read, o_wen_exec;
    logic [2:0] o_rx, o_ry;
    logic [14:0] o_wr;   // {WEN, done, RW, busW, zero, carry} during WRITE
    logic [2:0] o_end;   // {WEN, done, cmd_ready} after WRITE

    // Drive one command through the full four-cycle sequence and sample each phase.
    task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, input logic [7:0] imm);
        int waited = 0;
        while (cmd_ready !== 1'b1 && waited < 10) begin
            @(posedge Clk); #1;
            waited++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
        @(posedge Clk); #1;                       // E0: accepted
        cmd_valid = 1'b0;
        o_ready_read = cmd_ready; o_rx = RX; o_ry = RY;
        @(posedge Clk); #1;                       // E1: EXEC
        o_wen_exec = WEN;
        @(posedge Clk); #1;                       // E2: WRITE
        o_wr = {WEN, done, RW, busW, flag_zero, flag_carry};
        @(posedge Clk); #1;                       // E3: back in IDLE
        o_end = {WEN, done, cmd_ready};
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        rst_n = 1'b0; rf_clear = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        obs = {cmd_ready, WEN, done, RX, RY, RW, busW, flag_zero, flag_carry};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %h required %h", obs,
                     {1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0});
        end
        rst_n = 1'b1; rf_clear = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_li();
        run_cmd(OP_LI, 3'd3, 3'd0, 3'd0, 8'hA5);
        checks++;
        if ({o_ready_read, o_wen_exec} !== 2'b00) begin
            errors++;
            $display("FAIL li_busy: ready/wen got %b required 00", {o_ready_read, o_wen_exec});
        end
        checks++;
        if (o_wr !== {1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL li_write: got %h required %h", o_wr, {1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b0});
        end
        checks++;
        if (o_end !== 3'b001) begin
            errors++;
            $display("FAIL li_retire: wen/done/ready got %b required 001", o_end);
        end
        checks++;
        if (rf[3] !== 8'hA5) begin
            errors++;
            $display("FAIL li_rf: r3 got %h required a5", rf[3]);
        end
    endtask

    task automatic test_add();
        run_cmd(OP_LI, 3'd1, 3'd0, 3'd0, 8'hF0);
        run_cmd(OP_LI, 3'd2, 3'd0, 3'd0, 8'h20);
        run_cmd(OP_ADD, 3'd4, 3'd1, 3'd2, 8'h00);
        checks++;
        if ({o_rx, o_ry} !== {3'd1, 3'd2}) begin
            errors++;
            $display("FAIL add_read_addr: RX/RY got %0d/%0d required 1/2", o_rx, o_ry);
        end
        checks++;
        if (o_wr !== {1'b1, 1'b1, 3'd4, 8'h10, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_write: got %h required %h", o_wr, {1'b1, 1'b1, 3'd4, 8'h10, 1'b0, 1'b1});
        end
        checks++;
        if (rf[4] !== 8'h10) begin
            errors++;
            $display("FAIL add_rf: r4 got %h required 10", rf[4]);
        end
    endtask

    task automatic test_sub();
        run_cmd(OP_SUB, 3'd5, 3'd2, 3'd1, 8'h00);
        checks++;
        if (o_wr !== {1'b1, 1'b1, 3'd5, 8'h30, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_borrow: got %h required %h", o_wr, {1'b1, 1'b1, 3'd5, 8'h30, 1'b0, 1'b1});
        end
        run_cmd(OP_SUB, 3'd6, 3'd1, 3'd1, 8'h00);
        checks++;
        if (o_wr !== {1'b1, 1'b1, 3'd6, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_zero: got %h required %h", o_wr, {1'b1, 1'b1, 3'd6, 8'h00, 1'b1, 1'b0});
        end
        checks++;
        if (rf[5] !== 8'h30) begin
            errors++;
            $display("FAIL sub_rf: r5 got %h required 30", rf[5]);
        end
    endtask

    task automatic test_logic();
        logic [2:0] ops [4] = '{OP_ADD, OP_AND, OP_OR, OP_XOR};
        logic [7:0] res [4] = '{8'h10, 8'h20, 8'hF0, 8'hD0};
        logic       cy  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_cmd(ops[i], 3'd3, 3'd1, 3'd2, 8'h00);
            checks++;
            if (o_wr !== {1'b1, 1'b1, 3'd3, res[i], 1'b0, cy[i]}) begin
                errors++;
                $display("FAIL logic_op%0d: got %h required %h", i, o_wr,
                         {1'b1, 1'b1, 3'd3, res[i], 1'b0, cy[i]});
            end
        end
    endtask

    task automatic test_rd_zero();
        run_cmd(OP_ADDI, 3'd0, 3'd1, 3'd0, 8'h10);
        checks++;
        if (o_wr !== {1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL addi_r0: got %h required %h", o_wr, {1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 1'b1});
        end
        checks++;
        if (rf[0] !== 8'h00) begin
            errors++;
            $display("FAIL addi_r0_rf: r0 got %h required 00", rf[0]);
        end
        run_cmd(OP_NOP, 3'd2, 3'd1, 3'd2, 8'h55);
        checks++;
        if ({o_wr[14], o_wr[13], o_wr[1], o_wr[0]} !== 4'b0111) begin
            errors++;
            $display("FAIL nop: wen/done/zero/carry got %b required 0111",
                     {o_wr[14], o_wr[13], o_wr[1], o_wr[0]});
        end
        checks++;
        if (rf[2] !== 8'h20) begin
            errors++;
            $display("FAIL nop_rf: r2 got %h required 20", rf[2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] rdy;
        logic [7:0] r5_mid;
        logic [2:0] rx_second;
        cmd_valid = 1'b1; cmd_op = OP_LI; cmd_rd = 3'd5; cmd_rs = 3'd1; cmd_rt = 3'd0; cmd_imm = 8'h11;
        @(posedge Clk); #1;                       // E0: first accepted
        rdy[4] = cmd_ready;
        cmd_rd = 3'd6; cmd_rs = 3'd4; cmd_imm = 8'h22;  // second command, valid stays high
        @(posedge Clk); #1; rdy[3] = cmd_ready;
        @(posedge Clk); #1; rdy[2] = cmd_ready;
        @(posedge Clk); #1; rdy[1] = cmd_ready; r5_mid = rf[5];
        @(posedge Clk); #1; rdy[0] = cmd_ready; rx_second = RX;
        cmd_valid = 1'b0;
        checks++;
        if (rdy !== 5'b00010) begin
            errors++;
            $display("FAIL b2b_ready: pattern E0..E4 got %b required 00010", rdy);
        end
        checks++;
        if (r5_mid !== 8'h11 || rx_second !== 3'd4) begin
            errors++;
            $display("FAIL b2b_first: r5=%h RX=%0d required r5=11 RX=4", r5_mid, rx_second);
        end
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (rf[6] !== 8'h22) begin
            errors++;
            $display("FAIL b2b_second: r6 got %h required 22", rf[6]);
        end
    endtask

    task automatic test_reset_abort();
        run_cmd(OP_LI, 3'd7, 3'd0, 3'd0, 8'h77);
        checks++;
        if (rf[7] !== 8'h77) begin
            errors++;
            $display("FAIL abort_setup: r7 got %h required 77", rf[7]);
        end
        // reset while in EXEC of ADD r7
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 3'd7; cmd_rs = 3'd1; cmd_rt = 3'd2;
        @(posedge Clk); #1; cmd_valid = 1'b0;
        @(posedge Clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({WEN, done, cmd_ready, flag_zero, flag_carry} !== 5'b00100) begin
            errors++;
            $display("FAIL abort_exec: wen/done/ready/z/c got %b required 00100",
                     {WEN, done, cmd_ready, flag_zero, flag_carry});
        end
        @(posedge Clk); #1; rst_n = 1'b1;
        @(posedge Clk); #1;
        // reset while WEN is high in WRITE of LI r7
        cmd_valid = 1'b1; cmd_op = OP_LI; cmd_rd = 3'd7; cmd_imm = 8'h99;
        @(posedge Clk); #1; cmd_valid = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        checks++;
        if (WEN !== 1'b1) begin
            errors++;
            $display("FAIL abort_write_pre: WEN got %b required 1", WEN);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({WEN, done} !== 2'b00) begin
            errors++;
            $display("FAIL abort_write_drop: wen/done got %b required 00", {WEN, done});
        end
        @(posedge Clk); #1; rst_n = 1'b1;
        @(posedge Clk); #1;
        run_cmd(OP_ADD, 3'd3, 3'd7, 3'd0, 8'h00);
        checks++;
        if (o_rx !== 3'd7 || o_wr !== {1'b1, 1'b1, 3'd3, 8'h77, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_readback: RX=%0d write=%h required RX=7 write=%h", o_rx, o_wr,
                     {1'b1, 1'b1, 3'd3, 8'h77, 1'b0, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_li();
        test_add();
        test_sub();
        test_logic();
        test_rd_zero();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
